// File: rtl/reg_wr_arbiter_if.sv
// Bundle of load-push, execution-write and register-file write-port signals
// around reg_wr_arbiter. The arbiter takes the slave side.
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

interface reg_wr_arbiter_if #(
    parameter int WIDTH         = 16,
    parameter int N_THREADS     = 6,
    parameter int N_THREADS_MSB = `MSB(N_THREADS - 1),
    parameter int ADDR_MSB      = `REG_ADDR_MSB
);
    logic                     ld_req;
    logic [N_THREADS_MSB:0]   ld_thread;
    logic [ADDR_MSB:0]        ld_addr;
    logic [WIDTH-1:0]         ld_data;
    logic                     ld_ready;

    logic                     ex_wr_en;
    logic [1:0]               ex_sel;
    logic [N_THREADS_MSB:0]   ex_thread;
    logic [ADDR_MSB:0]        ex_addr;

    logic                     wr_en;
    logic                     mem_wr_en;
    logic [1:0]               reg_din_select;
    logic [WIDTH-1:0]         mem_din;
    logic [ADDR_MSB:0]        wr_addr;
    logic [N_THREADS_MSB:0]   wr_thread_num;
    logic [N_THREADS-1:0]     thread_pending;
    logic                     err;

    modport master (
        output ld_req, ld_thread, ld_addr, ld_data,
        output ex_wr_en, ex_sel, ex_thread, ex_addr,
        input  ld_ready, wr_en, mem_wr_en, reg_din_select, mem_din,
        input  wr_addr, wr_thread_num, thread_pending, err
    );

    modport slave (
        input  ld_req, ld_thread, ld_addr, ld_data,
        input  ex_wr_en, ex_sel, ex_thread, ex_addr,
        output ld_ready, wr_en, mem_wr_en, reg_din_select, mem_din,
        output wr_addr, wr_thread_num, thread_pending, err
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter: ex writes win, buffered loads drain otherwise.
// Optional feature: define REG_WR_BYPASS_EN to let a load into an empty FIFO skip it.
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

module reg_wr_arbiter #(
    parameter int WIDTH         = 16,
    parameter int N_THREADS     = 6,
    parameter int N_THREADS_MSB = `MSB(N_THREADS - 1),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              CLK,
    input  logic              rst_n,
    reg_wr_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TW    = N_THREADS_MSB + 1;
    localparam int AW    = `REG_ADDR_MSB + 1;

    logic [TW-1:0]    fifo_thread [FIFO_DEPTH];
    logic [AW-1:0]    fifo_addr   [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_data   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wr_en_q, wr_en_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] mem_din_q, mem_din_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [TW-1:0]    wr_thread_q, wr_thread_d;
    logic             err_q, err_d;

    logic             ex_grant, ex_bad, ld_ready, accept, drop, pop, push, bypass;
    logic [TW-1:0]    head_thread;
    logic [AW-1:0]    head_addr;
    logic [WIDTH-1:0] head_data;

    always_comb begin
        ex_grant    = bus.ex_wr_en && (bus.ex_sel != 2'd0);
        ex_bad      = bus.ex_wr_en && (bus.ex_sel == 2'd0);
        ld_ready    = count_q < CNT_W'(FIFO_DEPTH);
        accept      = bus.ld_req && ld_ready;
        drop        = bus.ld_req && !ld_ready;
        pop         = !ex_grant && (count_q != '0);
`ifdef REG_WR_BYPASS_EN
        bypass      = accept && (count_q == '0) && !ex_grant;
`else
        bypass      = 1'b0;
`endif
        push        = accept && !bypass;
        head_thread = fifo_thread[rd_ptr_q];
        head_addr   = fifo_addr[rd_ptr_q];
        head_data   = fifo_data[rd_ptr_q];

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Address/data/select hold their last value on idle cycles
        wr_en_d     = 1'b0;
        mem_wr_en_d = 1'b0;
        sel_d       = sel_q;
        mem_din_d   = mem_din_q;
        wr_addr_d   = wr_addr_q;
        wr_thread_d = wr_thread_q;
        if (ex_grant) begin
            wr_en_d     = 1'b1;
            sel_d       = bus.ex_sel;
            wr_addr_d   = bus.ex_addr;
            wr_thread_d = bus.ex_thread;
        end else if (pop) begin
            mem_wr_en_d = 1'b1;
            sel_d       = 2'd0;
            mem_din_d   = head_data;
            wr_addr_d   = head_addr;
            wr_thread_d = head_thread;
        end else if (bypass) begin
            mem_wr_en_d = 1'b1;
            sel_d       = 2'd0;
            mem_din_d   = bus.ld_data;
            wr_addr_d   = bus.ld_addr;
            wr_thread_d = bus.ld_thread;
        end

        err_d = err_q | drop | ex_bad;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_thread[wr_ptr_q] <= bus.ld_thread;
            fifo_addr[wr_ptr_q]   <= bus.ld_addr;
            fifo_data[wr_ptr_q]   <= bus.ld_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            mem_wr_en_q <= 1'b0;
            sel_q       <= 2'd0;
            mem_din_q   <= '0;
            wr_addr_q   <= '0;
            wr_thread_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            sel_q       <= sel_d;
            mem_din_q   <= mem_din_d;
            wr_addr_q   <= wr_addr_d;
            wr_thread_q <= wr_thread_d;
            err_q       <= err_d;
        end
    end

    // Per-thread count of loads still sitting in the FIFO
    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_pend
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             inc, dec;

        always_comb begin
            inc    = push && (bus.ld_thread == TW'(gi));
            dec    = pop && (head_thread == TW'(gi));
            pend_d = pend_q;
            if (inc && !dec) begin
                pend_d = pend_q + CNT_W'(1);
            end else if (dec && !inc) begin
                pend_d = pend_q - CNT_W'(1);
            end
        end

        always_ff @(posedge CLK) begin
            if (!rst_n) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_d;
            end
        end

        assign bus.thread_pending[gi] = (pend_q != '0);
    end

    assign bus.ld_ready       = ld_ready;
    assign bus.wr_en          = wr_en_q;
    assign bus.mem_wr_en      = mem_wr_en_q;
    assign bus.reg_din_select = sel_q;
    assign bus.mem_din        = mem_din_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_thread_num  = wr_thread_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomized and directed bench for reg_wr_arbiter against a queue-based model.
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

module tb_reg_wr_arbiter;
    localparam int WIDTH     = 16;
    localparam int N_THREADS = 6;
    localparam int TMSB      = 2;
    localparam int TW        = TMSB + 1;
    localparam int AMSB      = `REG_ADDR_MSB;
    localparam int AW        = AMSB + 1;
    localparam int DEPTH     = 4;
`ifdef REG_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [TW-1:0]    th;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
    } ent_t;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    reg_wr_arbiter_if #(
        .WIDTH(WIDTH), .N_THREADS(N_THREADS), .N_THREADS_MSB(TMSB), .ADDR_MSB(AMSB)
    ) bus ();

    reg_wr_arbiter #(
        .WIDTH(WIDTH), .N_THREADS(N_THREADS), .N_THREADS_MSB(TMSB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ent_t             q[$];
    logic             exp_wr_en = 1'b0, exp_mem = 1'b0, exp_err = 1'b0;
    logic [1:0]       exp_sel = '0;
    logic [WIDTH-1:0] exp_din = '0;
    logic [AW-1:0]    exp_addr = '0;
    logic [TW-1:0]    exp_th = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic step(input bit rst, input bit lq, input int lt, input int la, input int ld,
                        input bit ew, input int es, input int et, input int ea);
        bit   ready, exg, byp;
        ent_t e;
        logic [N_THREADS-1:0] pe;
        rst_n         = !rst;
        bus.ld_req    = lq;
        bus.ld_thread = TW'(lt);
        bus.ld_addr   = AW'(la);
        bus.ld_data   = WIDTH'(ld);
        bus.ex_wr_en  = ew;
        bus.ex_sel    = 2'(es);
        bus.ex_thread = TW'(et);
        bus.ex_addr   = AW'(ea);

        if (rst) begin
            q.delete();
            exp_wr_en = 0; exp_mem = 0; exp_err = 0;
            exp_sel = '0; exp_din = '0; exp_addr = '0; exp_th = '0;
        end else begin
            ready = q.size() < DEPTH;
            exg   = ew && (es != 0);
            if (lq && !ready) exp_err = 1'b1;
            if (ew && es == 0) exp_err = 1'b1;
            byp = BYPASS && lq && ready && (q.size() == 0) && !exg;
            exp_wr_en = 1'b0;
            exp_mem   = 1'b0;
            if (exg) begin
                exp_wr_en = 1'b1;
                exp_sel   = 2'(es);
                exp_addr  = AW'(ea);
                exp_th    = TW'(et);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_mem  = 1'b1;
                exp_sel  = 2'd0;
                exp_din  = e.d;
                exp_addr = e.a;
                exp_th   = e.th;
            end else if (byp) begin
                exp_mem  = 1'b1;
                exp_sel  = 2'd0;
                exp_din  = WIDTH'(ld);
                exp_addr = AW'(la);
                exp_th   = TW'(lt);
            end
            if (lq && ready && !byp) begin
                e.th = TW'(lt); e.a = AW'(la); e.d = WIDTH'(ld);
                q.push_back(e);
            end
        end

        @(posedge CLK);
        #1;
        cyc++;
        pe = '0;
        foreach (q[k]) pe[q[k].th] = 1'b1;

        if (bus.wr_en)
            $display("cyc %0d ex   sel=%0d th=%0d addr=%0d", cyc, bus.reg_din_select,
                     bus.wr_thread_num, bus.wr_addr);
        if (bus.mem_wr_en)
            $display("cyc %0d load th=%0d addr=%0d data=%h", cyc, bus.wr_thread_num,
                     bus.wr_addr, bus.mem_din);

        check_eq("wr_en", 32'(bus.wr_en), 32'(exp_wr_en));
        check_eq("mem_wr_en", 32'(bus.mem_wr_en), 32'(exp_mem));
        check_eq("reg_din_select", 32'(bus.reg_din_select), 32'(exp_sel));
        check_eq("mem_din", 32'(bus.mem_din), 32'(exp_din));
        check_eq("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
        check_eq("wr_thread_num", 32'(bus.wr_thread_num), 32'(exp_th));
        check_eq("ld_ready", 32'(bus.ld_ready), 32'(q.size() < DEPTH));
        check_eq("thread_pending", 32'(bus.thread_pending), 32'(pe));
        check_eq("err", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Loads buffered then discarded by a mid-run reset
        step(0, 1, 2, 3, 16'h1111, 0, 0, 0, 0);
        step(0, 1, 4, 2, 16'h2222, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Single ex write
        step(0, 0, 0, 0, 0, 1, 2, 3, 5);
        idle(1);

        // Single load
        step(0, 1, 1, 7, 16'hBEEF, 0, 0, 0, 0);
        idle(3);

        // Fill under ex strobes, overflow push, then drain in order
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, i, i + 8, 16'hA000 + i, 1, 1 + (i % 3), i, i);
        step(0, 1, 5, 15, 16'hDEAD, 1, 3, 5, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(5);

        // Pointer wrap: push and pop together on consecutive cycles
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++)
            step(0, 1, i, i, 16'h5000 + i, 1, 1, 0, i);
        for (int i = 0; i < 10; i++)
            step(0, 1, i % N_THREADS, i % 16, 16'hC000 + i, 0, 0, 0, 0);
        idle(5);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, N_THREADS - 1),
                 $urandom_range(0, (1 << AW) - 1),
                 $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 9) < 3,
                 ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3),
                 $urandom_range(0, N_THREADS - 1),
                 $urandom_range(0, (1 << AW) - 1));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
